// File: rtl/fb_uart_dump.sv
// Streams the 240x64 LCD framebuffer out through uart_tx, column by column,
// in the same byte order and bit packing the UART receive path loads it with.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, abort        begin a dump (pulse, idle only) / stop it (level)
//   busy, done          dump in progress / 1-cycle pulse after the last byte
//   fb_x, fb_col        framebuffer column address / column data (1-cycle read)
//   tx_data, tx_strobe  byte and load pulse to uart_tx
//   tx_busy             uart_tx is shifting
module fb_uart_dump #(
    parameter int         WIDTH     = 240,
    parameter int         ROWS      = 8,
    parameter bit         SYNC_EN   = 1'b1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [7:0]  fb_x,
    input  logic [63:0] fb_col,
    output logic [7:0]  tx_data,
    output logic        tx_strobe,
    input  logic        tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        FETCH,
        LATCH,
        SEND,
        HOLD
    } state_t;

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [2:0] Y_LAST = 3'(ROWS - 1);

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [2:0]  y_q, y_d;
    logic [63:0] col_q, col_d;
    logic [7:0]  data_q, data_d;
    logic        strobe_q, strobe_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    // Set while HOLD follows the sync byte rather than a pixel byte.
    logic        sync_hold_q, sync_hold_d;

    logic [7:0]  slice;
    logic [7:0]  rev;

    // The receive path stores rxd[0] at col[8y+7], so the slice goes out
    // bit-reversed to let a dumped image be re-sent unchanged.
    always_comb begin
        slice = col_q[{y_q, 3'b000} +: 8];
        rev   = '0;
        for (int k = 0; k < 8; k++) begin
            rev[k] = slice[7 - k];
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        col_d       = col_q;
        data_d      = data_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        sync_hold_d = sync_hold_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = SYNC_EN ? SYNC : FETCH;
                end
            end
            SYNC: begin
                if (!tx_busy) begin
                    strobe_d    = 1'b1;
                    data_d      = SYNC_BYTE;
                    sync_hold_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                col_d   = fb_col;
                y_d     = '0;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    strobe_d    = 1'b1;
                    data_d      = rev;
                    sync_hold_d = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // tx_busy is not looked at here: uart_tx may not have
                // raised it yet for the byte just loaded.
                if (sync_hold_q) begin
                    sync_hold_d = 1'b0;
                    state_d     = FETCH;
                end else if (y_q != Y_LAST) begin
                    y_d     = y_q + 3'd1;
                    state_d = SEND;
                end else if (x_q != X_LAST) begin
                    x_d     = x_q + 8'd1;
                    state_d = FETCH;
                end else begin
                    x_d     = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort overrides everything, including a start seen in IDLE.
        if (abort) begin
            state_d     = IDLE;
            strobe_d    = 1'b0;
            done_d      = 1'b0;
            data_d      = data_q;
            sync_hold_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            sync_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            col_q       <= col_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            sync_hold_q <= sync_hold_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fb_x      = x_q;
    assign tx_data   = data_q;
    assign tx_strobe = strobe_q;

endmodule

// File: tb/tb_fb_uart_dump.sv
// Bench for fb_uart_dump: framebuffer and uart_tx models, expected byte
// stream built from the packing rules, one per-cycle compare process.
module tb_fb_uart_dump;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  fb_x;
    logic [63:0] fb_col = 64'h0;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        tx_busy;

    localparam int NBYTES = 1921;

    logic [63:0] fb [0:239];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_b [0:NBYTES-1];

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit have_last = 1'b0;
    int min_gap = 2;
    logic [7:0] last_data = 8'h00;
    bit busy_mode = 1'b0;
    int busy_cnt = 0;

    fb_uart_dump dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .fb_x      (fb_x),
        .fb_col    (fb_col),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    // Framebuffer read port: registered, one cycle behind fb_x.
    always @(posedge clk) begin
        fb_col <= (fb_x < 8'd240) ? fb[fb_x] : 64'h0;
    end

    // uart_tx model: busy for 160 cycles after each load.
    always @(posedge clk) begin
        if (tx_strobe) busy_cnt <= 160;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = busy_mode && (busy_cnt != 0);

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7 - k];
        return r;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            last_data = 8'h00;
        end else begin
            chk("fb_x_in_range", (fb_x <= 8'd239), 1);
            if (tx_strobe) begin
                if (busy_mode) chk("strobe_while_busy", tx_busy, 0);
                if (have_last)
                    chk("strobe_gap", ((cyc - last_cyc) >= min_gap), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %0h, expected no byte",
                             tx_data);
                end else begin
                    chk($sformatf("byte_%0d", strobe_cnt), tx_data,
                        exp_q.pop_front());
                end
                if (strobe_cnt < NBYTES) got_b[strobe_cnt] = tx_data;
                strobe_cnt++;
                last_cyc = cyc;
                have_last = 1'b1;
                last_data = tx_data;
            end else begin
                chk("data_hold", tx_data, last_data);
            end
            if (done) begin
                chk("done_after_all_bytes", exp_q.size(), 0);
                done_cnt++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fill_ramp();
        for (int x = 0; x < 240; x++) fb[x] = {8{8'(x)}};
    endtask

    task automatic new_frame();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int x = 0; x < 240; x++)
            for (int y = 0; y < 8; y++)
                exp_q.push_back(bitrev(fb[x][8*y +: 8]));
        strobe_cnt = 0;
        done_cnt = 0;
        have_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int i = 0;
        while (strobe_cnt < n && i < budget) begin
            step();
            i++;
        end
        if (strobe_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL wait_strobes: got %0d strobes, expected %0d",
                     strobe_cnt, n);
        end
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && i < budget) begin
            step();
            i++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got no done pulse within %0d cycles",
                     budget);
        end
    endtask

    task automatic full_frame_tail();
        wait_done(6000);
        chk("frame_bytes", strobe_cnt, NBYTES);
        chk("done_busy_low", busy, 0);
        step();
        chk("done_one_cycle", done, 0);
        steps(10);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        steps(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_strobe", tx_strobe, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_fb_x", fb_x, 0);
        reset_n = 1'b1;
        steps(2);

        // Ramp frame, start latency, ignored second start at byte 500.
        fill_ramp();
        new_frame();
        chk("model_first_sync", exp_q[0], 8'hA5);
        chk("model_ramp_x3", exp_q[1 + 3*8], 8'hC0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("lat_busy_high", busy, 1);
        chk("lat_no_strobe_yet", tx_strobe, 0);
        step();
        chk("lat_strobe", tx_strobe, 1);
        chk("lat_sync_byte", tx_data, 8'hA5);
        wait_strobes(500, 2000);
        pulse_start();
        full_frame_tail();

        // Single set pixel, column register isolated from later writes.
        for (int x = 0; x < 240; x++) fb[x] = 64'h0;
        fb[0] = 64'h1;
        new_frame();
        chk("model_px_byte2", exp_q[1], 8'h80);
        chk("model_px_byte9", exp_q[8], 8'h00);
        pulse_start();
        wait_strobes(2, 100);
        fb[0] = '1;
        full_frame_tail();
        chk("px_byte2", got_b[1], 8'h80);
        chk("px_byte3_latched", got_b[2], 8'h00);
        chk("px_byte9", got_b[8], 8'h00);

        // Abort at byte 300, abort+start together, then a clean restart.
        fill_ramp();
        new_frame();
        pulse_start();
        wait_strobes(300, 2000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_low", busy, 0);
        chk("abort_no_strobe", tx_strobe, 0);
        steps(20);
        chk("abort_byte_count", strobe_cnt, 300);
        chk("abort_no_done", done_cnt, 0);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        steps(5);
        chk("abort_start_busy", busy, 0);
        chk("abort_start_bytes", strobe_cnt, 300);
        new_frame();
        pulse_start();
        full_frame_tail();

        // Slow uart_tx: spacing set by tx_busy.
        busy_mode = 1'b1;
        min_gap = 161;
        new_frame();
        pulse_start();
        wait_strobes(40, 8000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("slow_abort_busy", busy, 0);
        steps(200);
        chk("slow_no_done", done_cnt, 0);
        busy_mode = 1'b0;
        min_gap = 2;

        // Reset at byte 1000, then a full frame.
        new_frame();
        pulse_start();
        wait_strobes(1000, 3000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_strobe", tx_strobe, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_fb_x", fb_x, 0);
        steps(3);
        reset_n = 1'b1;
        steps(3);
        chk("mid_rst_no_done", done_cnt, 0);
        new_frame();
        pulse_start();
        full_frame_tail();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
